// File: rtl/cpu_ex_branch_if.sv
// EX-stage branch resolver bus: EX operands in, fetch-redirect and squash controls out.
interface cpu_ex_branch_if;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_ins;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_busy;
  logic [1:0]  pc_inc;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush;
  logic        link_we;
  logic [31:0] link_pc;

  modport master (
    output ex_valid, ex_pc, ex_ins, rs_data, rt_data, md_busy,
    input  pc_inc, next_pc, stall, flush, link_we, link_pc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_ins, rs_data, rt_data, md_busy,
    output pc_inc, next_pc, stall, flush, link_we, link_pc
  );
endinterface

// File: rtl/cpu_ex_branch.sv
// EX-stage control-flow resolver: same-cycle fetch redirect, then squash FLUSH_CYCLES wrong-path slots.
// Optional redirect/squash counters enabled by defining BRANCH_STATS_EN.
module cpu_ex_branch #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            clr_n,
  cpu_ex_branch_if.slave  bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     taken_count,
  output logic [31:0]     flush_count
`endif
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [1:0]  fcnt;
  logic [5:0]  opcode, funct;
  logic        is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
  logic        taken, redirect;
  logic [31:0] br_tgt, j_tgt;

  assign opcode  = bus.ex_ins[31:26];
  assign funct   = bus.ex_ins[5:0];
  assign is_beq  = (opcode == 6'h04);
  assign is_bne  = (opcode == 6'h05);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);
  assign is_jr   = (opcode == 6'h00) && (funct == 6'h08);
  assign is_jalr = (opcode == 6'h00) && (funct == 6'h09);

  assign taken = (is_beq && (bus.rs_data == bus.rt_data)) ||
                 (is_bne && (bus.rs_data != bus.rt_data)) ||
                 is_j || is_jal || is_jr || is_jalr;

  assign br_tgt = bus.ex_pc + 32'd1 + {{16{bus.ex_ins[15]}}, bus.ex_ins[15:0]};
  assign j_tgt  = {bus.ex_pc[31:26], bus.ex_ins[25:0]};

  // clr_n gating keeps every combinational output at its reset value while reset is held
  assign bus.stall   = bus.md_busy & clr_n;
  assign bus.flush   = (state == FLUSH);
  assign redirect    = clr_n && (state == IDLE) && bus.ex_valid && taken && !bus.stall;
  assign bus.link_we = clr_n && (state == IDLE) && bus.ex_valid && !bus.stall && (is_jal || is_jalr);
  assign bus.link_pc = bus.ex_pc + 32'd1;

  always_comb begin
    bus.pc_inc  = 2'b00;
    bus.next_pc = 32'd0;
    if (redirect) begin
      if (is_beq || is_bne) begin
        bus.pc_inc  = 2'b01;
        bus.next_pc = br_tgt;
      end else if (is_j || is_jal) begin
        bus.pc_inc  = 2'b10;
        bus.next_pc = j_tgt;
      end else begin
        bus.pc_inc  = 2'b11;
        bus.next_pc = bus.rs_data;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      fcnt  <= 2'd0;
    end else begin
      case (state)
        IDLE: if (redirect) begin
          state <= FLUSH;
          fcnt  <= FCNT_INIT;
        end
        FLUSH: if (!bus.stall) begin
          if (fcnt == 2'd0) state <= IDLE;
          else              fcnt  <= fcnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      taken_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (redirect)                 taken_count <= taken_count + 32'd1;
      if (bus.flush && !bus.stall)  flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_ex_branch.sv
// Randomized bench for cpu_ex_branch against a slot-counting reference model.
module tb_cpu_ex_branch;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ex_branch_if bus();
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count, flush_count;
  logic [31:0] m_tc = 0, m_fc = 0;
`endif

  cpu_ex_branch #(.FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count (taken_count),
    .flush_count (flush_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int fleft = 0;   // wrong-path slots still to squash

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_taken(input logic [31:0] ins, rs, rt);
    int op = int'(ins >> 26);
    int fn = int'(ins % 64);
    if (op == 4) return rs == rt;
    if (op == 5) return rs != rt;
    if (op == 2 || op == 3) return 1;
    if (op == 0 && (fn == 8 || fn == 9)) return 1;
    return 0;
  endfunction

  function automatic bit m_link(input logic [31:0] ins);
    int op = int'(ins >> 26);
    int fn = int'(ins % 64);
    return (op == 3) || (op == 0 && fn == 9);
  endfunction

  function automatic logic [31:0] m_cls(input logic [31:0] ins);
    int op = int'(ins >> 26);
    if (op == 4 || op == 5) return 1;
    if (op == 2 || op == 3) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] m_tgt(input logic [31:0] pc, ins, rs);
    int op = int'(ins >> 26);
    int imm = int'(ins % 65536);
    if (op == 4 || op == 5) begin
      if (imm >= 32768) imm = imm - 65536;
      return pc + 32'd1 + 32'(imm);
    end
    if (op == 2 || op == 3) return (pc & 32'hFC00_0000) | (ins & 32'h03FF_FFFF);
    return rs;
  endfunction

  task automatic cyc(input bit v, input logic [31:0] pc, ins, rs, rt, input bit busy);
    bit fl, tk, lk;
    @(negedge clk);
    bus.ex_valid = v; bus.ex_pc = pc; bus.ex_ins = ins;
    bus.rs_data = rs; bus.rt_data = rt; bus.md_busy = busy;
    #1;
    fl = (fleft > 0);
    tk = v && !fl && !busy && m_taken(ins, rs, rt);
    lk = v && !fl && !busy && m_link(ins);
    chk("pc_inc",  {30'd0, bus.pc_inc}, tk ? m_cls(ins) : 32'd0);
    chk("next_pc", bus.next_pc, tk ? m_tgt(pc, ins, rs) : 32'd0);
    chk("stall",   {31'd0, bus.stall}, {31'd0, busy});
    chk("flush",   {31'd0, bus.flush}, {31'd0, fl});
    chk("link_we", {31'd0, bus.link_we}, {31'd0, lk});
    chk("link_pc", bus.link_pc, pc + 32'd1);
`ifdef BRANCH_STATS_EN
    chk("taken_count", taken_count, m_tc);
    chk("flush_count", flush_count, m_fc);
`endif
    @(posedge clk);
`ifdef BRANCH_STATS_EN
    if (tk) m_tc++;
    if (fl && !busy) m_fc++;
`endif
    if (tk) fleft = FC;
    else if (fl && !busy) fleft--;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_flush"},   {31'd0, bus.flush}, 32'd0);
    chk({tag, "_pc_inc"},  {30'd0, bus.pc_inc}, 32'd0);
    chk({tag, "_next_pc"}, bus.next_pc, 32'd0);
    chk({tag, "_stall"},   {31'd0, bus.stall}, 32'd0);
    chk({tag, "_link_we"}, {31'd0, bus.link_we}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk({tag, "_taken_count"}, taken_count, 32'd0);
    chk({tag, "_flush_count"}, flush_count, 32'd0);
`endif
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] op, ins;
    case ($urandom_range(0, 6))
      0: op = 4;
      1: op = 5;
      2: op = 2;
      3: op = 3;
      4, 5: op = 0;
      default: op = 32'($urandom_range(0, 63));
    endcase
    ins = (op << 26) | ($urandom & 32'h03FF_FFFF);
    if (op == 0 && $urandom_range(0, 3) != 0)
      ins = (ins & ~32'h3F) | ($urandom_range(0, 1) ? 32'h09 : 32'h08);
    return ins;
  endfunction

  initial begin
    logic [31:0] rs, rt;
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h10; bus.ex_ins = 32'h1000_FFFC;
    bus.rs_data = 5; bus.rt_data = 5; bus.md_busy = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_outs("rst");
    @(negedge clk) clr_n = 1'b1;

    // BEQ taken backwards: 0x10 + 1 - 4
    cyc(1, 32'h10, 32'h1000_FFFC, 5, 5, 0);
    cyc(1, 32'h11, 32'h1000_FFFC, 5, 5, 0);
    cyc(1, 32'h12, 32'h1000_FFFC, 5, 5, 0);
    // BNE not taken, then JAL
    cyc(1, 32'h20, 32'h1400_0003, 7, 7, 0);
    cyc(1, 32'h4000_0020, 32'h0C00_0100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // JR deferred by md_busy for 3 cycles
    for (int i = 0; i < 3; i++) cyc(1, 32'h50, 32'h0000_0008, 32'h1234, 0, 1);
    cyc(1, 32'h50, 32'h0000_0008, 32'h1234, 0, 0);
    // stall pulse inside the flush window stretches it
    cyc(1, 32'h60, 32'h0800_0000, 0, 0, 0);
    cyc(1, 32'h61, 32'h0000_0009, 0, 0, 1);
    cyc(1, 32'h61, 32'h0000_0009, 0, 0, 1);
    cyc(1, 32'h61, 32'h0000_0009, 0, 0, 0);
    cyc(1, 32'h62, 32'h0000_0009, 0, 0, 0);
    // back-to-back: JALR right after the window
    cyc(1, 32'h63, 32'h0000_0009, 32'h77, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // reset asserted during the second flush cycle
    cyc(1, 32'h70, 32'h1000_0005, 1, 1, 0);
    cyc(1, 32'h71, 32'h0800_0000, 0, 0, 0);
    @(negedge clk);
    bus.md_busy = 1'b1; bus.ex_valid = 1'b1; bus.ex_ins = 32'h0800_0000;
    clr_n = 1'b0;
    #1 chk_reset_outs("midrst");
    fleft = 0;
`ifdef BRANCH_STATS_EN
    m_tc = 0; m_fc = 0;
`endif
    @(negedge clk) clr_n = 1'b1;
    cyc(1, 32'h80, 32'h1400_0010, 1, 2, 0);
    cyc(1, 32'h81, 32'h0000_0000, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rs = $urandom;
      rt = $urandom_range(0, 1) ? rs : $urandom;
      cyc($urandom_range(0, 4) != 0, $urandom, rnd_ins(), rs, rt, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
